// File: rtl/permutation_stream_collector_pkg.sv
// Shared pipeline constants and the stored entry format for the permutation collector.
// Bot width and series/throttle defaults are common to the generator and the collector.
`timescale 1ns/1ps
package permutation_stream_collector_pkg;

    localparam int unsigned BOT_W                   = 128;
    localparam int unsigned SERIES_LENGTH_DEFAULT   = 42;
    localparam int unsigned SLOWDOWN_MARGIN_DEFAULT = 56;
    localparam int unsigned SERIES_CNT_W            = 6;

    // 129-bit stored word: permuted bot plus its end-of-series marker
    typedef struct packed {
        logic [BOT_W-1:0] bot;
        logic             series_end;
    } entry_t;

endpackage

// File: rtl/permutation_stream_collector_buffer_ram.sv
// Simple dual-port entry RAM, one write port and one read port.
// Latency: read data registered one cycle after rd_addr; no backpressure, caller owns pointers.
`timescale 1ns/1ps
module collectorBufferRAM
    import permutation_stream_collector_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 7
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  entry_t                wr_dat,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output entry_t                rd_dat
);

    entry_t mem [2**DEPTH_LOG2];
    entry_t rd_dat_d;
    entry_t rd_dat_q;

    always_comb begin
        rd_dat_d = mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/permutation_stream_collector.sv
// Show-ahead collector FIFO for permuted bots; optional series-length check under PERMUTATION_SERIES_CHECK_EN.
// Latency: write to head in 1 cycle when empty; slowDown registered on occupancy, overflowing writes dropped (sticky flag).
`timescale 1ns/1ps
module permutation_stream_collector
    import permutation_stream_collector_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2      = 7,
    parameter int unsigned SLOWDOWN_MARGIN = SLOWDOWN_MARGIN_DEFAULT,
    parameter int unsigned SERIES_LENGTH   = SERIES_LENGTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BOT_W-1:0]   inputBot,
    input  logic               inputBotValid,
    input  logic               inputSeriesFinished,
    output logic               slowDown,
    output logic [BOT_W-1:0]   outputBot,
    output logic               outputBotValid,
    output logic               outputSeriesEnd,
    input  logic               outputReady,
    output logic [DEPTH_LOG2:0] occupancy,
    output logic [31:0]        seriesCompleted,
    output logic               overflowError
`ifdef PERMUTATION_SERIES_CHECK_EN
    ,
    output logic               seriesError
`endif
);

    localparam int unsigned         DEPTH       = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL    = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] SLOW_THRESH = (DEPTH_LOG2+1)'(DEPTH - SLOWDOWN_MARGIN);
    localparam logic [DEPTH_LOG2:0] ONE         = (DEPTH_LOG2+1)'(1);

    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   occ_q, occ_d;
    logic                  slow_q, slow_d;
    logic [31:0]           done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  open_q, open_d;
    logic                  fwd_sel_q, fwd_sel_d;
    entry_t                fwd_q, fwd_d;
    logic                  pop;
    logic                  wr_acc;
    logic [DEPTH_LOG2-1:0] rd_addr;
    entry_t                wr_entry;
    entry_t                ram_rd_dat;
    entry_t                head;

    always_comb begin
        wr_entry   = '{bot: inputBot, series_end: inputSeriesFinished};
        head       = fwd_sel_q ? fwd_q : ram_rd_dat;
        pop        = (occ_q != '0) && outputReady;
        // open_q blocks the first cycle after reset release
        wr_acc     = inputBotValid && open_q && ((occ_q != FULL_LVL) || pop);
        wr_ptr_d   = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + ONE : rd_ptr_q;
        occ_d      = occ_q;
        case ({wr_acc, pop})
            2'b10:   occ_d = occ_q + ONE;
            2'b01:   occ_d = occ_q - ONE;
            default: occ_d = occ_q;
        endcase
        slow_d     = occ_d > SLOW_THRESH;
        done_d     = (pop && head.series_end) ? done_q + 32'd1 : done_q;
        ovf_d      = ovf_q | (inputBotValid && open_q && !wr_acc);
        open_d     = 1'b1;
        // RAM reads the next head every cycle; a write landing on that address is forwarded instead
        rd_addr    = rd_ptr_d[DEPTH_LOG2-1:0];
        fwd_sel_d  = wr_acc && (wr_ptr_q[DEPTH_LOG2-1:0] == rd_addr);
        fwd_d      = wr_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            slow_q    <= 1'b0;
            done_q    <= '0;
            ovf_q     <= 1'b0;
            open_q    <= 1'b0;
            fwd_sel_q <= 1'b0;
            fwd_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            slow_q    <= slow_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            open_q    <= open_d;
            fwd_sel_q <= fwd_sel_d;
            fwd_q     <= fwd_d;
        end
    end

    collectorBufferRAM #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_dat  (wr_entry),
        .rd_addr (rd_addr),
        .rd_dat  (ram_rd_dat)
    );

    assign outputBotValid  = occ_q != '0;
    assign outputBot       = head.bot;
    assign outputSeriesEnd = outputBotValid && head.series_end;
    assign occupancy       = occ_q;
    assign slowDown        = slow_q;
    assign seriesCompleted = done_q;
    assign overflowError   = ovf_q;

`ifdef PERMUTATION_SERIES_CHECK_EN
    logic [SERIES_CNT_W-1:0] cnt_q, cnt_d;
    logic                    serr_q, serr_d;
    logic [SERIES_CNT_W:0]   cnt_inc;

    always_comb begin
        cnt_inc = {1'b0, cnt_q} + (SERIES_CNT_W+1)'(1);
        cnt_d   = cnt_q;
        serr_d  = serr_q;
        if (inputSeriesFinished && !inputBotValid) begin
            serr_d = 1'b1;
        end
        if (wr_acc) begin
            if (inputSeriesFinished) begin
                if (cnt_inc != (SERIES_CNT_W+1)'(SERIES_LENGTH)) begin
                    serr_d = 1'b1;
                end
                cnt_d = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_inc[SERIES_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            serr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            serr_q <= serr_d;
        end
    end

    assign seriesError = serr_q;
`else
    // series length only matters to the check logic
    localparam int unsigned SERIES_LENGTH_UNUSED = SERIES_LENGTH;
`endif

endmodule

// File: tb/tb_permutation_stream_collector.sv
// Bench for permutation_stream_collector: vector table, corner sequences, randomized traffic vs a queue model.
`timescale 1ns/1ps
`define CHK(n, a, e) chk(n, 160'(a), 160'(e))
module tb_permutation_stream_collector;

    localparam int DEPTH  = 128;
    localparam int MARGIN = 56;
    localparam int SLEN   = 42;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] inputBot = '0;
    logic         inputBotValid = 1'b0;
    logic         inputSeriesFinished = 1'b0;
    logic         outputReady = 1'b0;
    logic         slowDown;
    logic [127:0] outputBot;
    logic         outputBotValid;
    logic         outputSeriesEnd;
    logic [7:0]   occupancy;
    logic [31:0]  seriesCompleted;
    logic         overflowError;
`ifdef PERMUTATION_SERIES_CHECK_EN
    logic         seriesError;
`endif

    always #5 clk = ~clk;

    permutation_stream_collector dut (
        .clk                 (clk),
        .rst                 (rst),
        .inputBot            (inputBot),
        .inputBotValid       (inputBotValid),
        .inputSeriesFinished (inputSeriesFinished),
        .slowDown            (slowDown),
        .outputBot           (outputBot),
        .outputBotValid      (outputBotValid),
        .outputSeriesEnd     (outputSeriesEnd),
        .outputReady         (outputReady),
        .occupancy           (occupancy),
        .seriesCompleted     (seriesCompleted),
        .overflowError       (overflowError)
`ifdef PERMUTATION_SERIES_CHECK_EN
        ,
        .seriesError         (seriesError)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an ordered queue of stored entries plus sticky flags
    typedef struct {
        logic [127:0] bot;
        logic         fin;
    } ent_t;

    ent_t        mq[$];
    bit          m_first;
    bit          m_ovf;
    int unsigned m_done;
    bit          m_serr;
    int          m_cnt;

    task automatic compare_all(input string tag);
        `CHK({tag, "_occ"}, occupancy, mq.size());
        `CHK({tag, "_vld"}, outputBotValid, mq.size() != 0);
        if (mq.size() != 0) begin
            `CHK({tag, "_bot"}, outputBot, mq[0].bot);
            `CHK({tag, "_end"}, outputSeriesEnd, mq[0].fin);
        end
        `CHK({tag, "_slow"}, slowDown, mq.size() > DEPTH - MARGIN);
        `CHK({tag, "_ovf"}, overflowError, m_ovf);
        `CHK({tag, "_done"}, seriesCompleted, m_done);
`ifdef PERMUTATION_SERIES_CHECK_EN
        `CHK({tag, "_serr"}, seriesError, m_serr);
`endif
    endtask

    // One clock cycle: drive at negedge, advance model at posedge, compare at next negedge
    task automatic step(input logic vld, input logic [127:0] bot, input logic fin, input logic rdy);
        bit   pop;
        bit   acc;
        ent_t e;
        inputBotValid       = vld;
        inputBot            = bot;
        inputSeriesFinished = fin;
        outputReady         = rdy;
        pop = (mq.size() != 0) && rdy;
        acc = vld && !m_first && ((mq.size() < DEPTH) || pop);
        if (vld && !m_first && !acc) m_ovf = 1'b1;
        if (fin && !vld) m_serr = 1'b1;
        if (acc) begin
            if (fin) begin
                if (m_cnt + 1 != SLEN) m_serr = 1'b1;
                m_cnt = 0;
            end else if (m_cnt < 63) begin
                m_cnt++;
            end
        end
        @(posedge clk);
        if (pop) begin
            if (mq[0].fin) m_done++;
            void'(mq.pop_front());
        end
        if (acc) begin
            e.bot = bot;
            e.fin = fin;
            mq.push_back(e);
        end
        m_first = 1'b0;
        @(negedge clk);
        compare_all("step");
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases at a negedge
    task automatic reset_raw();
        #2;
        rst = 1'b1;
        #1;
        `CHK("rst_occ", occupancy, 0);
        `CHK("rst_vld", outputBotValid, 0);
        `CHK("rst_end", outputSeriesEnd, 0);
        `CHK("rst_slow", slowDown, 0);
        `CHK("rst_done", seriesCompleted, 0);
        `CHK("rst_ovf", overflowError, 0);
`ifdef PERMUTATION_SERIES_CHECK_EN
        `CHK("rst_serr", seriesError, 0);
`endif
        inputBotValid       = 1'b0;
        inputSeriesFinished = 1'b0;
        outputReady         = 1'b0;
        mq.delete();
        m_ovf  = 1'b0;
        m_done = 0;
        m_serr = 1'b0;
        m_cnt  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        m_first = 1'b1;
    endtask

    task automatic do_reset();
        reset_raw();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit           vld;
        logic [127:0] bot;
        bit           fin;
        bit           rdy;
        int           occ;
        bit           hv;
        logic [127:0] hbot;
        bit           hend;
        int           done;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 128'hA, 1'b0, 1'b0, 1, 1'b1, 128'hA, 1'b0, 0};
        tbl[1] = '{1'b1, 128'hB, 1'b1, 1'b0, 2, 1'b1, 128'hA, 1'b0, 0};
        tbl[2] = '{1'b0, 128'h0, 1'b0, 1'b1, 1, 1'b1, 128'hB, 1'b1, 0};
        tbl[3] = '{1'b0, 128'h0, 1'b0, 1'b1, 0, 1'b0, 128'h0, 1'b0, 1};
        tbl[4] = '{1'b0, 128'h0, 1'b0, 1'b1, 0, 1'b0, 128'h0, 1'b0, 1};
        tbl[5] = '{1'b1, 128'hC, 1'b0, 1'b1, 1, 1'b1, 128'hC, 1'b0, 1};
        tbl[6] = '{1'b1, 128'hD, 1'b1, 1'b1, 1, 1'b1, 128'hD, 1'b1, 1};
        tbl[7] = '{1'b0, 128'h0, 1'b0, 1'b0, 1, 1'b1, 128'hD, 1'b1, 1};
        tbl[8] = '{1'b0, 128'h0, 1'b0, 1'b1, 0, 1'b0, 128'h0, 1'b0, 2};

        // Vector table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].vld, tbl[i].bot, tbl[i].fin, tbl[i].rdy);
            `CHK($sformatf("tbl%0d_occ", i), occupancy, tbl[i].occ);
            `CHK($sformatf("tbl%0d_vld", i), outputBotValid, tbl[i].hv);
            if (tbl[i].hv) begin
                `CHK($sformatf("tbl%0d_bot", i), outputBot, tbl[i].hbot);
                `CHK($sformatf("tbl%0d_end", i), outputSeriesEnd, tbl[i].hend);
            end
            `CHK($sformatf("tbl%0d_done", i), seriesCompleted, tbl[i].done);
        end

        // First cycle after reset release accepts nothing
        reset_raw();
        step(1'b1, 128'h55, 1'b0, 1'b0);
        `CHK("open_drop_occ", occupancy, 0);
        step(1'b1, 128'h66, 1'b0, 1'b0);
        `CHK("open_acc_occ", occupancy, 1);
        `CHK("open_acc_bot", outputBot, 128'h66);
        `CHK("open_acc_ovf", overflowError, 0);

        // Full series streamed through with outputReady high
        do_reset();
        for (int i = 0; i < SLEN; i++) begin
            step(1'b1, 128'(1000 + i), 1'(i == SLEN - 1), 1'b1);
            checks++;
            if (outputBot !== 128'(1000 + i)) begin
                failures++;
                $display("FAIL series_head%0d: got %0h, expected %0h", i, outputBot, 1000 + i);
            end
            `CHK($sformatf("series_vld%0d", i), outputBotValid, 1);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        `CHK("series_done", seriesCompleted, 1);
`ifdef PERMUTATION_SERIES_CHECK_EN
        `CHK("series_serr", seriesError, 0);
`endif

        // slowDown threshold
        do_reset();
        for (int i = 0; i < 73; i++) begin
            step(1'b1, 128'(i), 1'b0, 1'b0);
            if (i == 71) `CHK("slow_at72", slowDown, 0);
        end
        `CHK("slow_occ73", occupancy, 73);
        `CHK("slow_at73", slowDown, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        `CHK("slow_pop_occ", occupancy, 72);
        `CHK("slow_pop", slowDown, 0);

        // Overflow: 129th write dropped, order preserved
        do_reset();
        for (int i = 0; i < 129; i++) step(1'b1, 128'(i), 1'b0, 1'b0);
        `CHK("ovf_occ", occupancy, 128);
        `CHK("ovf_flag", overflowError, 1);
        for (int i = 0; i < 128; i++) begin
            checks++;
            if (outputBot !== 128'(i)) begin
                failures++;
                $display("FAIL ovf_order%0d: got %0h, expected %0h", i, outputBot, i);
            end
            step(1'b0, '0, 1'b0, 1'b1);
        end
        `CHK("ovf_drained_vld", outputBotValid, 0);
        `CHK("ovf_drained_occ", occupancy, 0);

        // Write plus pop while full
        do_reset();
        for (int i = 0; i < 128; i++) step(1'b1, 128'(i), 1'b0, 1'b0);
        step(1'b1, 128'hABC, 1'b0, 1'b1);
        `CHK("full_wp_occ", occupancy, 128);
        `CHK("full_wp_ovf", overflowError, 0);
        `CHK("full_wp_head", outputBot, 1);
        for (int i = 0; i < 128; i++) step(1'b0, '0, 1'b0, 1'b1);

`ifdef PERMUTATION_SERIES_CHECK_EN
        // Short series flagged, correct series clean
        do_reset();
        for (int i = 0; i < SLEN - 1; i++) step(1'b1, 128'(i), 1'(i == SLEN - 2), 1'b1);
        `CHK("short_serr", seriesError, 1);
        do_reset();
        for (int i = 0; i < SLEN; i++) step(1'b1, 128'(i), 1'(i == SLEN - 1), 1'b1);
        `CHK("exact_serr", seriesError, 0);
`endif

        // Mid-stream reset at occupancy 30
        do_reset();
        for (int i = 0; i < 30; i++) step(1'b1, 128'(i), 1'b0, 1'b0);
        `CHK("mid_occ30", occupancy, 30);
        reset_raw();
        step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < SLEN; i++) begin
            step(1'b1, 128'(5000 + i), 1'(i == SLEN - 1), 1'b1);
            checks++;
            if (outputBot !== 128'(5000 + i)) begin
                failures++;
                $display("FAIL mid_head%0d: got %0h, expected %0h", i, outputBot, 5000 + i);
            end
        end
        step(1'b0, '0, 1'b0, 1'b1);
        `CHK("mid_done", seriesCompleted, 1);

        // Randomized traffic alternating drain-heavy and fill-heavy phases
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            logic [127:0] rb;
            logic         rv;
            logic         rf;
            logic         rr;
            rb = {$urandom, $urandom, $urandom, $urandom};
            rv = $urandom_range(0, 3) != 0;
            rf = $urandom_range(0, 9) == 0;
            rr = ((c / 250) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            step(rv, rb, rf, rr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/permutation_stream_collector.md
PERMUTATION_STREAM_COLLECTOR -- requirements
Module: permutation_stream_collector

Interface
REQ-001 SHALL have one clock `clk` and one reset `rst`; reset is asynchronous and active-high.
REQ-002 SHALL have parameter DEPTH_LOG2, default 7, giving buffer depth 2^DEPTH_LOG2 = 128 entries.
REQ-003 SHALL have parameter SLOWDOWN_MARGIN, default 56, giving the number of free entries below which slowDown asserts.
REQ-004 SHALL have parameter SERIES_LENGTH, default 42, giving the expected number of permutations per bot series.
REQ-005 SHALL have ports in this order:
- clk  in  1  clock
- rst  in  1  async active-high reset
- inputBot  in  128  permuted bot from the generator
- inputBotValid  in  1  inputBot is valid
- inputSeriesFinished  in  1  marks the last permutation of a series
- slowDown  out  1  throttle to the generator
- outputBot  out  128  head entry
- outputBotValid  out  1  head entry present
- outputSeriesEnd  out  1  head entry is the last permutation of its series
- outputReady  in  1  downstream pops the head entry
- occupancy  out  DEPTH_LOG2+1  entries stored
- seriesCompleted  out  32  series popped, wrapping
- overflowError  out  1  sticky

Function
REQ-006 SHALL write {inputBot, inputSeriesFinished} on every cycle with inputBotValid=1 that is accepted; cycles with inputBotValid=0 SHALL write nothing.
REQ-007 SHALL accept a write when occupancy < 2^DEPTH_LOG2, or when occupancy = 2^DEPTH_LOG2 and a pop occurs in the same cycle.
REQ-008 SHALL drop any other write, leave the buffer unchanged, and set overflowError until reset.
REQ-009 SHALL provide show-ahead output: an entry written in cycle N SHALL appear at the head no earlier than cycle N+1, and exactly at N+1 when the buffer was empty.
REQ-010 SHALL pop when outputBotValid && outputReady; outputReady with an empty buffer SHALL be ignored.
REQ-011 SHALL update occupancy by +1 on write only, -1 on pop only, and 0 on a simultaneous write and pop.
REQ-012 SHALL register slowDown as (occupancy_next > 2^DEPTH_LOG2 - SLOWDOWN_MARGIN), one cycle after the occupancy change.
- Reason: the generator finishes its current 42-cycle series after slowDown asserts.
REQ-013 SHALL increment seriesCompleted on each pop where outputSeriesEnd=1, wrapping modulo 2^32.
REQ-014 SHALL drive outputBot, outputSeriesEnd and outputBotValid from the same head entry, all stable while outputReady=0.
REQ-015 SHALL keep buffer pointers wrapping modulo 2^DEPTH_LOG2, with a separate full/empty distinction bit.

Reset
REQ-016 SHALL, on rst assertion and with no clock edge required, force: occupancy=0, outputBotValid=0, outputSeriesEnd=0, slowDown=0, seriesCompleted=0, overflowError=0, seriesError=0, pointers=0, and the series counter to 0.
- outputBot is don't-care while outputBotValid=0.
REQ-017 SHALL discard every stored entry when reset is asserted mid-operation.
REQ-018 SHALL accept no write in the first cycle after reset deassertion.

Configuration
REQ-019 SHALL, with PERMUTATION_SERIES_CHECK_EN defined, add output port seriesError (1 bit, sticky) and a 6-bit saturating input-side counter of accepted writes.
- On an accepted write with inputSeriesFinished=1: if counter+1 != SERIES_LENGTH, set seriesError; then clear the counter.
- inputSeriesFinished=1 with inputBotValid=0 also sets seriesError.
REQ-020 SHALL, without PERMUTATION_SERIES_CHECK_EN, have no seriesError port and no counter logic; all other behaviour is identical.

Structure
REQ-021 SHALL place the shared constants in the pipeline globals package/header: the bot width of 128, SERIES_LENGTH_DEFAULT=42 and SLOWDOWN_MARGIN_DEFAULT=56.
REQ-022 SHALL implement storage as one sub-module, collectorBufferRAM: a 129-bit-wide, 2^DEPTH_LOG2-deep simple dual-port RAM with a one-cycle registered read.
- Pointer, occupancy, head-prefetch and check logic stay in the top module.

Verification
REQ-023 SHALL verify, with outputReady=1: 42 consecutive valid inputs, last with finished=1 -> 42 outputs, each one cycle after input; seriesCompleted=1; seriesError=0.
REQ-024 SHALL verify, with outputReady=0: 73 writes -> occupancy=73 and slowDown=1 on the cycle after the 73rd write; pop 1 -> slowDown=0 one cycle later.
REQ-025 SHALL verify, with outputReady=0: 129 writes -> occupancy=128, overflowError=1; popping all 128 returns entries 0..127 in order, with the 129th absent.
REQ-026 SHALL verify, at occupancy=128: simultaneous write and pop -> occupancy stays 128; overflowError stays 0.
REQ-027 SHALL verify, with PERMUTATION_SERIES_CHECK_EN defined: a series of 41 writes with finished on the 41st -> seriesError=1; after reset, 42 writes -> seriesError=0.
REQ-028 SHALL verify: rst pulsed mid-stream at occupancy=30 -> occupancy=0 and outputBotValid=0 immediately; the next series is delivered intact.
